rv32i_decode_stage: RTL and testbench

//  Registered decode stage between instruction fetch and execute in the RV32I core.

---
 rtl/rv32i_decode_stage_pkg.sv | 52 +++++
 rtl/rv32i_decode_stage_decoder.sv | 95 +++++++++
 rtl/rv32i_decode_stage.sv | 79 +++++++
 tb/tb_rv32i_decode_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_decode_stage_pkg.sv
// Shared types and constants for the RV32I decode stage.
package rv32i_decode_stage_pkg;

  localparam int unsigned DPW = 32;
  localparam int unsigned ADW = 5;

  // Major opcode field, instr[6:0].
  typedef enum logic [6:0] {
    R_TYPE      = 7'b0110011,
    I_TYPE_ALU  = 7'b0010011,
    I_TYPE_LOAD = 7'b0000011,
    S_TYPE      = 7'b0100011,
    B_TYPE      = 7'b1100011
  } instr_type_t;

  // ADD_OP must stay at encoding 0 so an all-zero beat reads as ADD_OP.
  typedef enum logic [3:0] {
    ADD_OP = 4'd0,
    SUB_OP = 4'd1,
    AND_OP = 4'd2,
    OR_OP  = 4'd3,
    XOR_OP = 4'd4,
    SLL_OP = 4'd5,
    SRL_OP = 4'd6,
    SRA_OP = 4'd7,
    BEQ_OP = 4'd8
  } alu_op_t;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    instr_type_t    itype;
    alu_op_t        alu_op;
    logic [ADW-1:0] rs1;
    logic [ADW-1:0] rs2;
    logic [ADW-1:0] rd;
    logic [DPW-1:0] imm;
    logic           wen;
    logic           illegal;
  } dec_beat_t;

endpackage

// File: rtl/rv32i_decode_stage_decoder.sv
// Pure combinational RV32I instruction cracker: raw word -> decoded beat.
module rv32i_decoder
  import rv32i_decode_stage_pkg::*;
(
  input  logic [DPW-1:0] instr_i,
  output dec_beat_t      dec_o
);

  logic [2:0]     f3;
  logic [6:0]     f7;
  logic [DPW-1:0] imm_i, imm_s, imm_b;

  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};

  logic           legal;
  logic           wen_raw;
  logic           is_imm;
  alu_op_t        alu;
  logic [DPW-1:0] imm;

  // Classify by opcode/funct fields; any unrecognised encoding falls back to a safe illegal beat.
  always_comb begin
    legal   = 1'b0;
    wen_raw = 1'b0;
    is_imm  = 1'b0;
    alu     = ADD_OP;
    imm     = '0;
    unique case (instr_i[6:0])
      R_TYPE, I_TYPE_ALU: begin
        is_imm  = (instr_i[6:0] == I_TYPE_ALU);
        wen_raw = 1'b1;
        imm     = is_imm ? imm_i : '0;
        // For immediate forms f7 is part of the immediate except on shifts.
        case (f3)
          F3_ADD_SUB: begin
            if (is_imm || f7 == F7_BASE) begin
              legal = 1'b1;
              alu   = ADD_OP;
            end else if (f7 == F7_ALT) begin
              legal = 1'b1;
              alu   = SUB_OP;
            end
          end
          F3_AND: begin legal = is_imm || f7 == F7_BASE; alu = AND_OP; end
          F3_OR:  begin legal = is_imm || f7 == F7_BASE; alu = OR_OP;  end
          F3_XOR: begin legal = is_imm || f7 == F7_BASE; alu = XOR_OP; end
          F3_SLL: begin legal = (f7 == F7_BASE);         alu = SLL_OP; end
          F3_SR: begin
            if (f7 == F7_BASE) begin
              legal = 1'b1;
              alu   = SRL_OP;
            end else if (f7 == F7_ALT) begin
              legal = 1'b1;
              alu   = SRA_OP;
            end
          end
          default: ;
        endcase
      end
      I_TYPE_LOAD: begin
        legal   = (f3 == F3_WORD);
        wen_raw = 1'b1;
        imm     = imm_i;
      end
      S_TYPE: begin
        legal = (f3 == F3_WORD);
        imm   = imm_s;
      end
      B_TYPE: begin
        legal = (f3 == F3_BEQ);
        alu   = BEQ_OP;
        imm   = imm_b;
      end
      default: ;
    endcase
  end

  // Assemble the beat; register fields are always the raw instruction fields.
  always_comb begin
    dec_o         = '0;
    dec_o.itype   = instr_type_t'(instr_i[6:0]);
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.rd      = instr_i[11:7];
    dec_o.alu_op  = legal ? alu : ADD_OP;
    dec_o.imm     = legal ? imm : '0;
    dec_o.wen     = legal && wen_raw && (instr_i[11:7] != '0);
    dec_o.illegal = !legal;
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered decode stage: one-entry valid/ready pipeline register around rv32i_decoder.
module rv32i_decode_stage
  import rv32i_decode_stage_pkg::*;
(
  input  logic           clk_i,
  input  logic           arst_ni,
  input  logic           flush_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [DPW-1:0] in_pc_i,
  input  logic [DPW-1:0] in_instr_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [DPW-1:0] out_pc_o,
  output logic [6:0]     out_type_o,
  output logic [3:0]     out_alu_op_o,
  output logic [ADW-1:0] out_rs1_o,
  output logic [ADW-1:0] out_rs2_o,
  output logic [ADW-1:0] out_rd_o,
  output logic [DPW-1:0] out_imm_o,
  output logic           out_wen_o,
  output logic           out_illegal_o
);

  dec_beat_t      dec;
  dec_beat_t      beat_q, beat_d;
  logic [DPW-1:0] pc_q, pc_d;
  logic           valid_q, valid_d;
  logic           accept;

  rv32i_decoder u_decoder (
    .instr_i (in_instr_i),
    .dec_o   (dec)
  );

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  // Next-state: flush beats accept, accept beats drain, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      beat_d  = dec;
      pc_d    = in_pc_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register; all-zero reset doubles as ADD_OP on the alu field.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_pc_o      = pc_q;
  assign out_type_o    = beat_q.itype;
  assign out_alu_op_o  = beat_q.alu_op;
  assign out_rs1_o     = beat_q.rs1;
  assign out_rs2_o     = beat_q.rs2;
  assign out_rd_o      = beat_q.rd;
  assign out_imm_o     = beat_q.imm;
  assign out_wen_o     = beat_q.wen;
  assign out_illegal_o = beat_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Self-checking bench for rv32i_decode_stage: directed cases plus random traffic against a reference model.
module tb_rv32i_decode_stage;
  import rv32i_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_imm;
  logic [6:0]  out_type;
  logic [3:0]  out_alu;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_wen, out_ill;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: is a beat held, and which raw pc/instr it came from.
  logic        m_valid;
  logic [31:0] m_pc, m_instr;

  always #5 clk = ~clk;

  rv32i_decode_stage dut (
    .clk_i         (clk),
    .arst_ni       (arst_n),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_pc_i       (in_pc),
    .in_instr_i    (in_instr),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_type_o    (out_type),
    .out_alu_op_o  (out_alu),
    .out_rs1_o     (out_rs1),
    .out_rs2_o     (out_rs2),
    .out_rd_o      (out_rd),
    .out_imm_o     (out_imm),
    .out_wen_o     (out_wen),
    .out_illegal_o (out_ill)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set rules: match full {f7,f3,opcode} patterns.
  // kind: 0 illegal, 1 register op, 2 immediate op/load, 3 store, 4 branch.
  task automatic ref_decode(input logic [31:0] ins, output logic [3:0] alu,
                            output logic [31:0] imm, output logic wen, output logic ill);
    int kind;
    logic [31:0] sgn;
    sgn  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    kind = 0;
    alu  = 4'(ADD_OP);
    casez ({ins[31:25], ins[14:12], ins[6:0]})
      17'b0000000_000_0110011: begin kind = 1; alu = 4'(ADD_OP); end
      17'b0100000_000_0110011: begin kind = 1; alu = 4'(SUB_OP); end
      17'b0000000_111_0110011: begin kind = 1; alu = 4'(AND_OP); end
      17'b0000000_110_0110011: begin kind = 1; alu = 4'(OR_OP);  end
      17'b0000000_100_0110011: begin kind = 1; alu = 4'(XOR_OP); end
      17'b0000000_001_0110011: begin kind = 1; alu = 4'(SLL_OP); end
      17'b0000000_101_0110011: begin kind = 1; alu = 4'(SRL_OP); end
      17'b0100000_101_0110011: begin kind = 1; alu = 4'(SRA_OP); end
      17'b???????_000_0010011: begin kind = 2; alu = 4'(ADD_OP); end
      17'b???????_111_0010011: begin kind = 2; alu = 4'(AND_OP); end
      17'b???????_110_0010011: begin kind = 2; alu = 4'(OR_OP);  end
      17'b???????_100_0010011: begin kind = 2; alu = 4'(XOR_OP); end
      17'b0000000_001_0010011: begin kind = 2; alu = 4'(SLL_OP); end
      17'b0000000_101_0010011: begin kind = 2; alu = 4'(SRL_OP); end
      17'b0100000_101_0010011: begin kind = 2; alu = 4'(SRA_OP); end
      17'b???????_010_0000011: begin kind = 2; alu = 4'(ADD_OP); end
      17'b???????_010_0100011: begin kind = 3; alu = 4'(ADD_OP); end
      17'b???????_000_1100011: begin kind = 4; alu = 4'(BEQ_OP); end
      default:                 begin kind = 0; alu = 4'(ADD_OP); end
    endcase
    case (kind)
      2:       imm = (sgn & 32'hFFFF_F000) + 32'(ins[31:20] & 12'h7FF) + (ins[31] ? 32'h800 : 32'h0);
      3:       imm = (sgn & 32'hFFFF_F000) + 32'(ins[31:25]) * 32 + 32'(ins[11:7]);
      4:       imm = (sgn & 32'hFFFF_E000) + (ins[31] ? 32'h1000 : 32'h0) + 32'(ins[7]) * 2048
                     + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
      default: imm = 32'h0;
    endcase
    wen = (kind == 1 || kind == 2) && (ins[11:7] != 5'd0);
    ill = (kind == 0);
  endtask

  task automatic check_beat(input string tag);
    logic [3:0]  e_alu;
    logic [31:0] e_imm;
    logic        e_wen, e_ill;
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      ref_decode(m_instr, e_alu, e_imm, e_wen, e_ill);
      chk({tag, ".pc"},   out_pc, m_pc);
      chk({tag, ".type"}, 32'(out_type), 32'(m_instr[6:0]));
      chk({tag, ".alu"},  32'(out_alu), 32'(e_alu));
      chk({tag, ".rs1"},  32'(out_rs1), 32'(m_instr[19:15]));
      chk({tag, ".rs2"},  32'(out_rs2), 32'(m_instr[24:20]));
      chk({tag, ".rd"},   32'(out_rd), 32'(m_instr[11:7]));
      chk({tag, ".imm"},  out_imm, e_imm);
      chk({tag, ".wen"},  32'(out_wen), 32'(e_wen));
      chk({tag, ".ill"},  32'(out_ill), 32'(e_ill));
    end
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs at next negedge.
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic [31:0] ins, input logic ordy, input logic fl);
    logic rdy;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
    rdy = !m_valid || ordy;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (fl) m_valid = 1'b0;
    else if (v && rdy) begin
      m_valid = 1'b1;
      m_pc    = pc;
      m_instr = ins;
    end else if (ordy) m_valid = 1'b0;
    @(negedge clk);
    check_beat(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [6];
    logic [6:0] f7;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011};
    case ($urandom_range(0, 2))
      0:       f7 = 7'b0000000;
      1:       f7 = 7'b0100000;
      default: f7 = 7'($urandom);
    endcase
    if ($urandom_range(0, 4) == 0) return $urandom;
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), ops[$urandom_range(0, 5)]};
  endfunction

  logic [31:0] stream [8];

  initial begin
    arst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    m_valid = 1'b0; m_pc = '0; m_instr = '0;
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.pc",    out_pc, 32'd0);
    chk("rst.type",  32'(out_type), 32'd0);
    chk("rst.alu",   32'(out_alu), 32'(ADD_OP));
    chk("rst.regs",  32'({out_rs1, out_rs2, out_rd}), 32'd0);
    chk("rst.imm",   out_imm, 32'd0);
    chk("rst.flags", 32'({out_wen, out_ill}), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    arst_n = 1'b1;

    // Directed decodes.
    cycle("add", 1'b1, 32'h100, 32'h002081B3, 1'b1, 1'b0);
    chk("add.type_const", 32'(out_type), 32'(R_TYPE));
    chk("add.alu_const",  32'(out_alu), 32'(ADD_OP));
    chk("add.wen_const",  32'(out_wen), 32'd1);
    cycle("sub", 1'b1, 32'h104, 32'h407302B3, 1'b1, 1'b0);
    chk("sub.alu_const", 32'(out_alu), 32'(SUB_OP));
    cycle("addi", 1'b1, 32'h108, 32'hFFF00093, 1'b1, 1'b0);
    chk("addi.imm_const", out_imm, 32'hFFFF_FFFF);
    cycle("sw", 1'b1, 32'h10C, 32'h0020A423, 1'b1, 1'b0);
    chk("sw.imm_const", out_imm, 32'h8);
    chk("sw.wen_const", 32'(out_wen), 32'd0);
    cycle("beq", 1'b1, 32'h110, 32'hFE208EE3, 1'b1, 1'b0);
    chk("beq.alu_const", 32'(out_alu), 32'(BEQ_OP));
    chk("beq.imm_const", out_imm, 32'hFFFF_FFFC);
    cycle("ecall", 1'b1, 32'h114, 32'h00000073, 1'b1, 1'b0);
    chk("ecall.ill_const", 32'(out_ill), 32'd1);
    chk("ecall.wen_const", 32'(out_wen), 32'd0);

    // Backpressure: held beat stays put while new beats are offered.
    cycle("stall_load", 1'b1, 32'h200, 32'h00C12283, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("stall", 1'b1, 32'h204 + 32'(i), 32'h00308133, 1'b0, 1'b0);
    cycle("release", 1'b1, 32'h300, 32'h40315193, 1'b1, 1'b0);
    cycle("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain.no_dup", 32'(out_valid), 32'd0);

    // Back-to-back stream with no bubbles.
    for (int i = 0; i < 8; i++) stream[i] = rand_instr();
    for (int i = 0; i < 8; i++) cycle("stream", 1'b1, 32'h400 + 32'(4 * i), stream[i], 1'b1, 1'b0);
    cycle("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a held beat and an offered beat, blocked and unblocked.
    cycle("fl_load", 1'b1, 32'h500, 32'h002081B3, 1'b0, 1'b0);
    cycle("flush_held", 1'b1, 32'h504, 32'h407302B3, 1'b0, 1'b1);
    cycle("fl_load2", 1'b1, 32'h508, 32'h0020A423, 1'b0, 1'b0);
    cycle("flush_open", 1'b1, 32'h50C, 32'hFE208EE3, 1'b1, 1'b1);
    chk("flush.valid_const", 32'(out_valid), 32'd0);

    // Reset while a beat is held.
    cycle("rst_load", 1'b1, 32'h600, 32'hFFF00093, 1'b0, 1'b0);
    #2 arst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.imm",   out_imm, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    cycle("post_rst_idle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      cycle("rand", $urandom_range(0, 3) != 0, $urandom, rand_instr(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
